afifo_rd_port: RTL and testbench
================================

Name: afifo_rd_port

Overview:
Read-domain half of the next-generation parametrised asynchronous FIFO. The write domain supplies a Gray write pointer; this block synchronises it, owns the Gray/binary read pointer, drives the dual-port RAM read port, and computes Empty, AlmostEmpty and fill level. It adds a selectable first-word-fall-through (FWFT) mode with full-rate valid/ready handshake and a registered underflow flag.

Parameters:
DATA_WIDTH, 8, word width
ADDRESS_WIDTH, 4, RAM address bits; depth = 2**ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits
SYNC_STAGES, 2, flops in the write-pointer synchroniser (>=2)
ALMOST_EMPTY_THRESH, 2, AlmostEmpty_out asserted when RdLevel_out <= this value
FWFT, 1, 1 = first-word-fall-through, 0 = standard read-enable mode

Ports:
RClk  in  1  read clock; all logic on rising edge
PresetFull  in  1  reset, asynchronous, active-high
WrPtrGray_in  in  ADDRESS_WIDTH+1  write pointer (Gray), WClk-registered
RdPtrGray_out  out  ADDRESS_WIDTH+1  registered read pointer (Gray) to write domain
MemRdEn_out  out  1  RAM read enable (combinational)
MemRdAddr_out  out  ADDRESS_WIDTH  RAM read address = read binary pointer LSBs
MemRdData_in  in  DATA_WIDTH  RAM data, valid the cycle after MemRdEn_out
ReadEn_in  in  1  FWFT: ready/ack; standard: read request
Data_out  out  DATA_WIDTH  read data
Valid_out  out  1  Data_out holds a word
Empty_out  out  1  no word available to reader
AlmostEmpty_out  out  1  RdLevel_out <= ALMOST_EMPTY_THRESH
RdLevel_out  out  ADDRESS_WIDTH+1  words visible to reader (0..2**ADDRESS_WIDTH)
Underflow_out  out  1  one-cycle pulse on ReadEn_in while Empty_out

Behaviour:
- Reset (async, immediate): pointers, synchroniser, skid/in-flight state, Data_out, RdLevel_out = 0; Empty_out = 1; AlmostEmpty_out = 1; Valid_out = 0; Underflow_out = 0. RAM data in flight is discarded. Write domain must be reset in the same event.
- Sync: WrPtrGray_in passes through SYNC_STAGES flops, then Gray->binary gives wbin. Read pointer rbin/rgray are ADDRESS_WIDTH+1 bits, wrap mod 2**(ADDRESS_WIDTH+1). RdPtrGray_out = registered rgray.
- mem_avail = (rgray != synchronised wgray). mem_level = (wbin - rbin) mod 2**(ADDRESS_WIDTH+1).
- An issue (MemRdEn_out=1) advances rbin/rgray at that edge. Issues occur only when mem_avail, so pointer never overtakes the write pointer.
- FWFT=1: output register plus one-entry skid register plus in-flight flag. local = Valid_out + skid_valid + inflight. pop = Valid_out & ReadEn_in. Issue when mem_avail and (local - pop) < 2. An arriving word goes to Data_out if !Valid_out or pop, else to skid. On pop with skid_valid, skid moves to Data_out. Sustains 1 word/cycle. Empty_out = !Valid_out. Data_out is stable while Valid_out & !ReadEn_in.
- FWFT=0: issue = ReadEn_in & mem_avail. Data_out <= MemRdData_in at the edge after issue. Valid_out pulses high for that one cycle. Data_out holds otherwise. Empty_out = !mem_avail.
- First-word latency (FWFT=1): Valid_out rises SYNC_STAGES+2 RClk edges after the WrPtrGray_in change is first sampled.
- RdLevel_out is registered: mem_level + local in FWFT mode, mem_level in standard mode. It is pessimistic by the sync latency and never exceeds 2**ADDRESS_WIDTH.
- AlmostEmpty_out is registered from the next-state level.
- Underflow_out is a registered pulse when ReadEn_in & Empty_out. State is otherwise unchanged.
- Simultaneous pop and arrival in the same cycle: no loss, no reordering.

Decomposition:
- Package afifo_pkg: bin2gray / gray2bin functions, ptr_w = ADDRESS_WIDTH+1 localparam convention, FWFT mode constants.
- Sub-module afifo_ptr_sync: SYNC_STAGES-deep Gray-pointer synchroniser with async reset. It is reused by the write-side port.

Test Plan:
- Reset mid-stream with 5 words pending, PresetFull pulsed between edges -> Empty_out=1, Valid_out=0, RdPtrGray_out=0, RdLevel_out=0 before the next edge; no MemRdEn_out until new writes arrive.
- FWFT=1, WrPtrGray_in 0 -> 1 (word 0xA5) -> Valid_out=1 with Data_out=0xA5 exactly 4 edges later (SYNC_STAGES=2).
- FIFO full (WrPtrGray_in=5'b11000, data 0..15), ReadEn_in held high -> 16 consecutive Valid&ReadEn cycles with data 0..15 in order, then Empty_out=1, RdPtrGray_out=5'b11000.
- 3 words present, ReadEn_in low for 5 cycles -> at most 2 issues, Data_out stable; on release the words arrive in order with no bubble.
- 40-word interleaved write/read stream -> pointers wrap 31->0 without error, data order intact, RdLevel_out<=16, AlmostEmpty_out tracks threshold 2.
- FWFT=0: ReadEn_in while empty -> Underflow_out pulse, rbin unchanged; ReadEn_in with word 0x3C -> Data_out=0x3C and Valid_out pulse at issue edge +1.

Source files
------------

// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared pointer helpers and mode constants for the asynchronous FIFO ports
package afifo_pkg;

  // Helpers work on a wide vector; callers cast down to their pointer width.
  localparam int PTR_MAX_W = 16;

  localparam bit FWFT_MODE = 1'b1;
  localparam bit STD_MODE  = 1'b0;

  function automatic int ptr_w(input int address_width);
    return address_width + 1;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_ptr_sync.sv
// rtl/afifo_ptr_sync.sv - multi-flop Gray pointer synchroniser, shared by both FIFO ports
module afifo_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/afifo_rd_port.sv
// rtl/afifo_rd_port.sv - read-domain half of the asynchronous FIFO with optional FWFT output stage
module afifo_rd_port
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDRESS_WIDTH       = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter bit FWFT                = FWFT_MODE
) (
  input  logic                     RClk,
  input  logic                     PresetFull,
  input  logic [ADDRESS_WIDTH:0]   WrPtrGray_in,
  output logic [ADDRESS_WIDTH:0]   RdPtrGray_out,
  output logic                     MemRdEn_out,
  output logic [ADDRESS_WIDTH-1:0] MemRdAddr_out,
  input  logic [DATA_WIDTH-1:0]    MemRdData_in,
  input  logic                     ReadEn_in,
  output logic [DATA_WIDTH-1:0]    Data_out,
  output logic                     Valid_out,
  output logic                     Empty_out,
  output logic                     AlmostEmpty_out,
  output logic [ADDRESS_WIDTH:0]   RdLevel_out,
  output logic                     Underflow_out
);

  localparam int PW = ptr_w(ADDRESS_WIDTH);
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  logic [PW-1:0]         wgray_sync, wbin, rbin, rbin_n, rgray_n, mem_level, level_d;
  logic                  mem_avail, issue, pop, inflight, skid_valid;
  logic [1:0]            local_cnt;
  logic [DATA_WIDTH-1:0] skid_data;

  afifo_ptr_sync #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_wsync (
    .clk  (RClk),
    .reset(PresetFull),
    .d    (WrPtrGray_in),
    .q    (wgray_sync)
  );

  assign wbin      = PW'(gray2bin(PTR_MAX_W'(wgray_sync)));
  assign mem_avail = (RdPtrGray_out != wgray_sync);
  assign mem_level = wbin - rbin;

  // Words already pulled out of the RAM: output register, skid entry, RAM read in flight.
  assign local_cnt = {1'b0, Valid_out} + {1'b0, skid_valid} + {1'b0, inflight};
  assign pop       = (FWFT == FWFT_MODE) & Valid_out & ReadEn_in;

  always_comb begin
    issue   = 1'b0;
    level_d = mem_level;
    if (FWFT == FWFT_MODE) begin
      issue   = mem_avail && ((local_cnt - {1'b0, pop}) < 2'd2);
      level_d = mem_level + PW'(local_cnt) - PW'(pop);
    end else begin
      issue   = ReadEn_in && mem_avail;
      level_d = mem_level - PW'(issue);
    end
  end

  assign rbin_n        = rbin + PW'(issue);
  assign rgray_n       = PW'(bin2gray(PTR_MAX_W'(rbin_n)));
  assign MemRdEn_out   = issue;
  assign MemRdAddr_out = rbin[ADDRESS_WIDTH-1:0];
  assign Empty_out     = (FWFT == STD_MODE) ? !mem_avail : !Valid_out;

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      rbin            <= '0;
      RdPtrGray_out   <= '0;
      inflight        <= 1'b0;
      skid_valid      <= 1'b0;
      skid_data       <= '0;
      Data_out        <= '0;
      Valid_out       <= 1'b0;
      RdLevel_out     <= '0;
      AlmostEmpty_out <= 1'b1;
      Underflow_out   <= 1'b0;
    end else begin
      rbin            <= rbin_n;
      RdPtrGray_out   <= rgray_n;
      inflight        <= issue;
      RdLevel_out     <= level_d;
      AlmostEmpty_out <= (level_d <= AE_THRESH);
      Underflow_out   <= ReadEn_in & Empty_out;
      if (FWFT == FWFT_MODE) begin
        // The skid entry is always older than a word arriving from the RAM.
        if (pop) begin
          if (skid_valid) begin
            Data_out <= skid_data;
            if (inflight) begin
              skid_data <= MemRdData_in;
            end else begin
              skid_valid <= 1'b0;
            end
          end else if (inflight) begin
            Data_out <= MemRdData_in;
          end else begin
            Valid_out <= 1'b0;
          end
        end else if (inflight) begin
          if (!Valid_out) begin
            Data_out  <= MemRdData_in;
            Valid_out <= 1'b1;
          end else begin
            skid_data  <= MemRdData_in;
            skid_valid <= 1'b1;
          end
        end
      end else begin
        Valid_out <= inflight;
        if (inflight) begin
          Data_out <= MemRdData_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_port.sv
// tb/tb_afifo_rd_port.sv - directed bench for afifo_rd_port in FWFT and standard modes
module tb_afifo_rd_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] wptr_f, wgray_f, rdgray_f, level_f;
  logic [4:0] wptr_s, wgray_s, rdgray_s, level_s;
  logic [3:0] addr_f, addr_s;
  logic [7:0] rdata_f, rdata_s, data_f, data_s;
  logic       rden_f, ren_f, valid_f, empty_f, ae_f, uf_f;
  logic       rden_s, ren_s, valid_s, empty_s, ae_s, uf_s;
  logic [7:0] mem_f [16];
  logic [7:0] mem_s [16];

  int errors = 0;
  int checks = 0;

  afifo_rd_port #(.FWFT(1'b1)) u_fwft (
    .RClk(clk), .PresetFull(rst), .WrPtrGray_in(wgray_f), .RdPtrGray_out(rdgray_f),
    .MemRdEn_out(rden_f), .MemRdAddr_out(addr_f), .MemRdData_in(rdata_f),
    .ReadEn_in(ren_f), .Data_out(data_f), .Valid_out(valid_f), .Empty_out(empty_f),
    .AlmostEmpty_out(ae_f), .RdLevel_out(level_f), .Underflow_out(uf_f)
  );

  afifo_rd_port #(.FWFT(1'b0)) u_std (
    .RClk(clk), .PresetFull(rst), .WrPtrGray_in(wgray_s), .RdPtrGray_out(rdgray_s),
    .MemRdEn_out(rden_s), .MemRdAddr_out(addr_s), .MemRdData_in(rdata_s),
    .ReadEn_in(ren_s), .Data_out(data_s), .Valid_out(valid_s), .Empty_out(empty_s),
    .AlmostEmpty_out(ae_s), .RdLevel_out(level_s), .Underflow_out(uf_s)
  );

  // Registered-output RAM models: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (rden_f) rdata_f <= mem_f[addr_f];
    if (rden_s) rdata_s <= mem_s[addr_s];
  end

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] from_gray(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulsed between edges; write side is reset in the same event.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    wptr_f = 5'd0; wgray_f = 5'd0; wptr_s = 5'd0; wgray_s = 5'd0;
    ren_f = 1'b0; ren_s = 1'b0;
    #2;
    check({tag, "_empty"}, 32'(empty_f), 32'd1);
    check({tag, "_valid"}, 32'(valid_f), 32'd0);
    check({tag, "_rdgray"}, 32'(rdgray_f), 32'd0);
    check({tag, "_level"}, 32'(level_f), 32'd0);
    check({tag, "_ae"}, 32'(ae_f), 32'd1);
    check({tag, "_data"}, 32'(data_f), 32'd0);
    check({tag, "_std_empty"}, 32'(empty_s), 32'd1);
    check({tag, "_std_valid"}, 32'(valid_s), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       ren;
    logic [4:0] wbin;
    logic       valid;
    logic [7:0] data;
    logic       empty;
    logic [4:0] level;
    logic       memrden;
    logic       uf;
    logic       ae;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, first, last, issues, popped, wr_cnt;
    logic [4:0] maxlvl, rptr, diff;
    logic stable_bad, lvl_bad, ae_bad, any_rd;

    //          ren   wbin   valid data   empty level memrden uf   ae
    vecs[0] = '{1'b0, 5'd1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 5'd1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 5'd1, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 5'd1, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 5'd1, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 5'd1, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    wptr_f = 5'd0; wgray_f = 5'd0; wptr_s = 5'd0; wgray_s = 5'd0;
    ren_f = 1'b0; ren_s = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_f[i] = 8'h00;
      mem_s[i] = 8'h00;
    end
    step();
    step();
    check("rst_empty", 32'(empty_f), 32'd1);
    check("rst_valid", 32'(valid_f), 32'd0);
    check("rst_ae", 32'(ae_f), 32'd1);
    check("rst_level", 32'(level_f), 32'd0);
    check("rst_uf", 32'(uf_f), 32'd0);
    check("rst_memrden", 32'(rden_f), 32'd0);
    rst = 1'b0;

    // First-word latency and FWFT pop/underflow, one edge per row.
    mem_f[0] = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      ren_f = vecs[i].ren;
      wptr_f = vecs[i].wbin;
      wgray_f = to_gray(wptr_f);
      step();
      check($sformatf("lat%0d_valid", i), 32'(valid_f), 32'(vecs[i].valid));
      check($sformatf("lat%0d_data", i), 32'(data_f), 32'(vecs[i].data));
      check($sformatf("lat%0d_empty", i), 32'(empty_f), 32'(vecs[i].empty));
      check($sformatf("lat%0d_level", i), 32'(level_f), 32'(vecs[i].level));
      check($sformatf("lat%0d_memrden", i), 32'(rden_f), 32'(vecs[i].memrden));
      check($sformatf("lat%0d_uf", i), 32'(uf_f), 32'(vecs[i].uf));
      check($sformatf("lat%0d_ae", i), 32'(ae_f), 32'(vecs[i].ae));
    end

    // Full FIFO drained with ReadEn held high.
    step();
    pulse_reset("rst_full");
    for (int i = 0; i < 16; i++) mem_f[i] = 8'(i);
    wptr_f = 5'd16; wgray_f = to_gray(wptr_f);
    check("full_wgray_const", 32'(wgray_f), 32'h18);
    ren_f = 1'b1;
    got = 0; first = -1; last = -1; maxlvl = 5'd0;
    for (int cyc = 0; cyc < 80 && got < 16; cyc++) begin
      step();
      if (level_f > maxlvl) maxlvl = level_f;
      if (valid_f) begin
        check($sformatf("full_data%0d", got), 32'(data_f), 32'(got));
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    check("full_count", 32'(got), 32'd16);
    step();
    ren_f = 1'b0;
    check("full_contiguous", 32'(last - first), 32'd15);
    check("full_maxlevel", 32'(maxlvl), 32'd16);
    check("full_empty_after", 32'(empty_f), 32'd1);
    check("full_rdgray_after", 32'(rdgray_f), 32'h18);
    check("full_level_after", 32'(level_f), 32'd0);

    // Three words with the reader stalled, then released.
    mem_f[0] = 8'h30; mem_f[1] = 8'h31; mem_f[2] = 8'h32;
    wptr_f = 5'd19; wgray_f = to_gray(wptr_f);
    issues = 0; stable_bad = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (rden_f) issues++;
      if (valid_f && data_f !== 8'h30) stable_bad = 1'b1;
    end
    check("stall_issues_le2", 32'(issues <= 2), 32'd1);
    check("stall_valid", 32'(valid_f), 32'd1);
    check("stall_data", 32'(data_f), 32'h30);
    check("stall_data_stable", 32'(stable_bad), 32'd0);
    ren_f = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("release%0d_valid", k), 32'(valid_f), 32'd1);
      check($sformatf("release%0d_data", k), 32'(data_f), 32'(8'h30 + k));
      step();
    end
    ren_f = 1'b0;
    check("release_empty", 32'(empty_f), 32'd1);

    // Interleaved 40-word stream across the pointer wrap.
    popped = 0; wr_cnt = 0; lvl_bad = 1'b0; ae_bad = 1'b0;
    for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
      ren_f = ($urandom_range(0, 3) != 0);
      if (valid_f && ren_f) begin
        check($sformatf("wrap_data%0d", popped), 32'(data_f), 32'(8'h40 + popped));
        popped++;
      end
      if (level_f > 5'd16) lvl_bad = 1'b1;
      if (ae_f !== (level_f <= 5'd2)) ae_bad = 1'b1;
      rptr = from_gray(rdgray_f);
      diff = wptr_f - rptr;
      if (wr_cnt < 40 && diff < 5'd16 && $urandom_range(0, 2) != 0) begin
        mem_f[wptr_f[3:0]] = 8'(8'h40 + wr_cnt);
        wptr_f = wptr_f + 5'd1;
        wgray_f = to_gray(wptr_f);
        wr_cnt++;
      end
      step();
    end
    ren_f = 1'b0;
    check("wrap_popped", 32'(popped), 32'd40);
    check("wrap_level_bound", 32'(lvl_bad), 32'd0);
    check("wrap_ae_tracks", 32'(ae_bad), 32'd0);
    check("wrap_rdgray_final", 32'(rdgray_f), 32'(to_gray(5'd27)));

    // Reset with five words pending.
    for (int k = 0; k < 5; k++) begin
      mem_f[wptr_f[3:0]] = 8'(8'h80 + k);
      wptr_f = wptr_f + 5'd1;
    end
    wgray_f = to_gray(wptr_f);
    for (int cyc = 0; cyc < 6; cyc++) step();
    check("mid_valid_before", 32'(valid_f), 32'd1);
    pulse_reset("rst_mid");
    any_rd = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      if (rden_f) any_rd = 1'b1;
    end
    check("mid_no_memrden", 32'(any_rd), 32'd0);
    check("mid_empty_hold", 32'(empty_f), 32'd1);

    // Standard mode: underflow, then a single read-enable transaction.
    ren_s = 1'b1;
    step();
    check("std_uf_pulse", 32'(uf_s), 32'd1);
    check("std_uf_rdgray", 32'(rdgray_s), 32'd0);
    check("std_uf_memrden", 32'(rden_s), 32'd0);
    ren_s = 1'b0;
    step();
    check("std_uf_clear", 32'(uf_s), 32'd0);
    mem_s[0] = 8'h3C;
    wptr_s = 5'd1; wgray_s = to_gray(wptr_s);
    step(); step(); step();
    check("std_empty_avail", 32'(empty_s), 32'd0);
    check("std_level_one", 32'(level_s), 32'd1);
    ren_s = 1'b1;
    #1;
    check("std_memrden", 32'(rden_s), 32'd1);
    check("std_memaddr", 32'(addr_s), 32'd0);
    step();
    ren_s = 1'b0;
    check("std_issue_rdgray", 32'(rdgray_s), 32'd1);
    check("std_issue_valid", 32'(valid_s), 32'd0);
    check("std_issue_empty", 32'(empty_s), 32'd1);
    check("std_issue_level", 32'(level_s), 32'd0);
    step();
    check("std_valid_pulse", 32'(valid_s), 32'd1);
    check("std_data", 32'(data_s), 32'h3C);
    check("std_no_uf", 32'(uf_s), 32'd0);
    step();
    check("std_valid_drop", 32'(valid_s), 32'd0);
    check("std_data_hold", 32'(data_s), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
